// File: rtl/unary_popcount_accumulator.sv
// Unary-to-binary reduction stage of the unary-binary MAC.
// Each accepted beat adds popcount(unary_bits) to a saturating accumulator.
// After WINDOW accepted beats the sum is offered on a valid/ready output.
module unary_popcount_accumulator #(
    parameter int unsigned SIZE   = 4,
    parameter int unsigned LANES  = 1 << SIZE,
    parameter int unsigned WINDOW = 1 << SIZE,
    parameter int unsigned OUT_W  = SIZE << 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [LANES-1:0] unary_bits,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned POP_W = $clog2(LANES + 1);
    localparam int unsigned ACC_W = OUT_W + 1;
    localparam int unsigned SUM_W = ((ACC_W > POP_W) ? ACC_W : POP_W) + 1;
    localparam int unsigned CNT_W = $clog2(WINDOW) + 1;

    // acc clamps at 2^OUT_W once saturated, so its MSB alone flags saturation
    localparam logic [ACC_W-1:0] ACC_SAT   = ACC_W'(1) << OUT_W;
    localparam logic [SUM_W-1:0] SAT_LIMIT = SUM_W'(ACC_SAT) - SUM_W'(1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;
    logic [OUT_W-1:0]   res_next;
    logic [POP_W-1:0]   pop;
    logic [SUM_W-1:0]   sum;

    // Population count of the current beat
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            pop = pop + POP_W'(unary_bits[i]);
        end
    end

    assign sum = SUM_W'(acc) + SUM_W'(pop);

    // Next-state and next datapath values; start overrides everything but reset
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = overflow;
        if (start) begin
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (sum > SAT_LIMIT) begin
                            acc_next = ACC_SAT;
                            ovf_next = 1'b1;
                        end else begin
                            acc_next = ACC_W'(sum);
                        end
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        res_next = acc_next[OUT_W] ? '1 : acc_next[OUT_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator, beat counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            acc       <= acc_next;
            cnt       <= cnt_next;
            result    <= res_next;
            overflow  <= ovf_next;
            out_valid <= (state_next == DONE);
            busy      <= (state_next == ACCUM);
        end
    end

endmodule

// File: tb/tb_unary_popcount_accumulator.sv
// Self-checking bench for unary_popcount_accumulator.
// Expected sums come from a MAC-level model: sum of $countones over accepted beats.
module tb_unary_popcount_accumulator;

    localparam int unsigned SIZE   = 4;
    localparam int unsigned LANES  = 1 << SIZE;
    localparam int unsigned WINDOW = 1 << SIZE;
    localparam int unsigned OUT_W  = SIZE << 1;
    localparam int          MAXRES = (1 << OUT_W) - 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [LANES-1:0] unary_bits;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] result;
    logic             overflow;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [LANES-1:0] bits;
        logic             valid;
    } beat_t;

    beat_t seq[$];

    unary_popcount_accumulator #(
        .SIZE  (SIZE),
        .LANES (LANES),
        .WINDOW(WINDOW),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .unary_bits(unary_bits),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Unary encoding of a*b+c for beat j: lanes 0..b-1 carry unary a, MSB lane carries unary c
    function automatic logic [LANES-1:0] mac_beat(input int a, input int b, input int c, input int j);
        logic [LANES-1:0] v;
        v = '0;
        for (int l = 0; l < int'(LANES) - 1; l++) begin
            v[l] = (l < b) && (j < a);
        end
        v[LANES-1] = (j < c);
        return v;
    endfunction

    // Build a window of WINDOW valid beats for a,b,c with `gaps` idle cycles mid-window
    task automatic build_mac(input int a, input int b, input int c, input int gaps);
        int gap_at[WINDOW];
        for (int j = 0; j < int'(WINDOW); j++) gap_at[j] = 0;
        for (int g = 0; g < gaps; g++) gap_at[$urandom_range(1, WINDOW - 1)]++;
        seq.delete();
        for (int j = 0; j < int'(WINDOW); j++) begin
            for (int g = 0; g < gap_at[j]; g++) begin
                seq.push_back('{bits: LANES'($urandom), valid: 1'b0});
            end
            seq.push_back('{bits: mac_beat(a, b, c, j), valid: 1'b1});
        end
    endtask

    // Optionally pulse start, play seq, then check the window's outcome against the model
    task automatic play(input string tag, input bit do_start);
        int exp_sum;
        int early;
        int n;
        exp_sum = 0;
        early   = 0;
        n       = seq.size();
        foreach (seq[i]) if (seq[i].valid) exp_sum += $countones(seq[i].bits);
        if (do_start) begin
            start      = 1'b1;
            in_valid   = 1'($urandom);
            unary_bits = LANES'($urandom);
            step();
            start = 1'b0;
            check({tag, "_start_busy"}, 32'(busy), 32'd1);
            check({tag, "_start_result"}, 32'(result), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            unary_bits = seq[i].bits;
            in_valid   = seq[i].valid;
            step();
            if (i < n - 1 && out_valid !== 1'b0) early++;
        end
        in_valid = 1'b0;
        check({tag, "_early_valid"}, 32'(early), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'((exp_sum > MAXRES) ? MAXRES : exp_sum));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_sum > MAXRES));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    // Complete the output handshake and confirm return to IDLE
    task automatic consume(input string tag);
        logic [OUT_W-1:0] held;
        held      = result;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_hs_busy"}, 32'(busy), 32'd0);
        check({tag, "_hs_result_kept"}, 32'(result), 32'(held));
    endtask

    initial begin
        int bad;
        logic [OUT_W-1:0] held;
        reset      = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        unary_bits = '0;
        out_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // in_valid in IDLE must not start anything
        in_valid   = 1'b1;
        unary_bits = '1;
        step();
        step();
        in_valid = 1'b0;
        check("idle_ignore_valid", 32'(out_valid), 32'd0);
        check("idle_ignore_busy", 32'(busy), 32'd0);

        // 5*3+2 = 17
        build_mac(5, 3, 2, 0);
        play("mac532", 1'b1);
        check("mac532_exact", 32'(result), 32'h11);
        consume("mac532");

        // Same with 3 idle cycles mid-window
        build_mac(5, 3, 2, 3);
        check("gap_len", 32'(seq.size()), 32'(WINDOW + 3));
        play("mac532_gap", 1'b1);
        consume("mac532_gap");

        // All lanes set for every beat: 256 saturates
        seq.delete();
        for (int j = 0; j < int'(WINDOW); j++) seq.push_back('{bits: '1, valid: 1'b1});
        play("allones", 1'b1);
        check("allones_ff", 32'(result), 32'hFF);
        consume("allones");
        start = 1'b1;
        step();
        start = 1'b0;
        check("allones_restart_ovf", 32'(overflow), 32'd0);
        build_mac(2, 2, 1, 0);
        play("after_ovf", 1'b0);
        check("after_ovf_exact", 32'(result), 32'd5);

        // Hold out_ready low in DONE for 10 cycles, with junk beats presented
        held = result;
        bad  = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid   = 1'b1;
            unary_bits = LANES'($urandom);
            step();
            if (out_valid !== 1'b1 || result !== held || busy !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        check("hold_stable", 32'(bad), 32'd0);
        consume("hold");

        // Abort at beat 7 with all-ones presented: that beat must not count
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 7; j++) begin
            in_valid   = 1'b1;
            unary_bits = LANES'($urandom);
            step();
        end
        start      = 1'b1;
        in_valid   = 1'b1;
        unary_bits = '1;
        step();
        start = 1'b0;
        check("abort_result", 32'(result), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_ovf", 32'(overflow), 32'd0);
        seq.delete();
        for (int j = 0; j < int'(WINDOW); j++) seq.push_back('{bits: '0, valid: 1'b1});
        play("abort_zero", 1'b0);
        check("abort_zero_exact", 32'(result), 32'd0);

        // start in DONE without out_ready: result dropped, restart
        start = 1'b1;
        step();
        start = 1'b0;
        check("done_restart_valid", 32'(out_valid), 32'd0);
        check("done_restart_busy", 32'(busy), 32'd1);
        build_mac(7, 9, 4, 2);
        play("r_794", 1'b0);
        check("r_794_exact", 32'(result), 32'd67);

        // start in DONE with out_ready: handshake and restart on the same edge
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        check("done_hs_restart_valid", 32'(out_valid), 32'd0);
        check("done_hs_restart_busy", 32'(busy), 32'd1);
        build_mac(1, 1, 0, 1);
        play("r_110", 1'b0);
        consume("r_110");

        // Reset at beat 9 discards the partial window
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 9; j++) begin
            in_valid   = 1'b1;
            unary_bits = '1;
            step();
        end
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        check("midrst_quiet", 32'(bad), 32'd0);
        build_mac(15, 15, 15, 0);
        play("mac_max", 1'b1);
        check("mac_max_exact", 32'(result), 32'd240);
        consume("mac_max");

        // Randomized MAC windows with random gaps
        for (int r = 0; r < 6; r++) begin
            build_mac(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
            play($sformatf("rnd%0d", r), 1'b1);
            consume($sformatf("rnd%0d", r));
        end

        // Randomized raw lane patterns, some of which saturate
        for (int r = 0; r < 4; r++) begin
            seq.delete();
            for (int j = 0; j < int'(WINDOW); j++) begin
                if ($urandom_range(0, 3) == 0) seq.push_back('{bits: LANES'($urandom), valid: 1'b0});
                seq.push_back('{bits: LANES'($urandom) | LANES'($urandom), valid: 1'b1});
            end
            play($sformatf("raw%0d", r), 1'b1);
            consume($sformatf("raw%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unary_popcount_accumulator.md
Name: unary_popcount_accumulator

Overview:
- Downstream stage of the unary-binary MAC: consumes the masked, fanned-out unary lane vector one beat per cycle and reduces it to a binary sum, so that out = a*b + c.
- Each beat contributes popcount(lane vector). Lanes 0..LANES-2 carry the b-weighted copies of unary a; lane LANES-1 carries unary c.
- The sum over a window of WINDOW beats is presented on a valid/ready output.

Parameters:
- SIZE, 4, operand width of the upstream MAC (a, b, c are SIZE bits).
- LANES, 1<<SIZE, number of unary lanes per beat; the MSB lane is the c lane.
- WINDOW, 1<<SIZE, number of accepted beats per accumulation.
- OUT_W, SIZE<<1, result width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle pulse; clears the accumulator and opens a new window.
- in_valid, input, 1, unary_bits valid this cycle.
- unary_bits, input, LANES, masked unary lanes; bit LANES-1 is the c lane.
- out_ready, input, 1, downstream accepts result.
- out_valid, output, 1, result valid.
- result, output, OUT_W, accumulated sum, saturated.
- overflow, output, 1, sum exceeded 2^OUT_W-1 in the current window.
- busy, output, 1, high in ACCUM.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state=IDLE, out_valid=0, result=0, overflow=0, busy=0, beat counter=0.
- Reset has priority over all other inputs. Reset mid-window discards the partial sum; no out_valid follows.
- State IDLE:
  - in_valid is ignored.
  - start -> ACCUM next cycle, with acc=0, overflow=0, beat count=0.
- State ACCUM:
  - busy=1.
  - A beat is accepted at each edge where in_valid=1.
  - On each accepted beat: acc <= acc + popcount(unary_bits), and the beat count increments.
  - No latency beyond the register: the sum is updated on the accepting edge.
  - Cycles with in_valid=0 neither add nor count.
- Leaving ACCUM:
  - On the edge that accepts beat number WINDOW, go to DONE.
  - That edge includes that beat's popcount, so out_valid=1 is visible the cycle after the final beat.
- State DONE:
  - out_valid=1; result and overflow are held stable until the handshake.
  - in_valid is ignored.
  - The output is consumed on the edge where out_valid & out_ready. Then go to IDLE and drop out_valid. result keeps its last value.
- start during ACCUM: abort and restart. acc=0, count=0, overflow=0, and the beat presented in that same cycle is NOT added.
- start during DONE:
  - Without out_ready: the result is discarded (no handshake) and the block restarts into ACCUM.
  - With out_ready: the handshake completes and the block restarts into ACCUM on the same edge.
  - In both cases out_valid deasserts.
- Width rules:
  - popcount is computed at $clog2(LANES+1) bits; acc is internally OUT_W+1 bits.
  - If the sum exceeds 2^OUT_W-1, result saturates to all-ones and overflow goes high. overflow is sticky until the next start or reset.
  - With the default parameters, any legal MAC input pattern (max 15*15+15=240) never saturates. The maximal lane pattern (256) saturates.
- Beat counter: $clog2(WINDOW)+1 bits. It never wraps inside a window; it is cleared on start.

Test Plan:
- Reset, then a=5, b=3, c=2 pattern: start, then 16 beats with in_valid=1. Beats 0..1 carry lanes {0,1,2,15}; beats 2..4 carry lanes {0,1,2}; the rest carry 0. -> out_valid one cycle after beat 16, result=17 (8'h11), overflow=0.
- Same stimulus with in_valid deasserted for 3 random cycles mid-window -> out_valid delayed by exactly 3 cycles, result=17.
- All lanes=1 for all 16 beats -> result=8'hFF, overflow=1. Next start clears overflow to 0.
- out_ready held low 10 cycles in DONE -> out_valid and result stable for all 10 cycles. Raising out_ready gives IDLE next cycle with out_valid=0.
- start asserted at beat 7 of a window with unary_bits=all-ones -> that beat is not counted. 16 further zero beats give result=0.
- reset pulsed at beat 9 -> all outputs 0 next cycle, no out_valid. A subsequent start with a=15, b=15, c=15 pattern gives result=240.
